// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: data word, opcode encoding,
// decoded control word and the MEM-stage controller state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       d_cache_read;
        logic       d_cache_write;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HIGH = 2'b10;
    localparam logic [1:0] BE_LOW  = 2'b01;

    // LDI/STI need a pointer fetch before the real access.
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for the d-cache port: lane enables and replicated
// store data on the way out, byte extraction on the way back.
module mem_byte_align
    import lc3b_types::*;
(
    input  lc3b_opcode i_opcode,
    input  logic       i_byte_sel,
    input  lc3b_word   i_wdata,
    input  lc3b_word   i_rdata,
    output logic [1:0] o_byte_enable,
    output lc3b_word   o_wdata,
    output lc3b_word   o_rdata
);

    logic w_is_byte;

    assign w_is_byte = is_byte_op(i_opcode);

    // Word ops use both lanes unchanged; byte ops pick one lane by addr[0].
    always_comb begin
        o_byte_enable = BE_WORD;
        o_wdata       = i_wdata;
        o_rdata       = i_rdata;
        if (w_is_byte) begin
            o_byte_enable = i_byte_sel ? BE_HIGH : BE_LOW;
            o_wdata       = {i_wdata[7:0], i_wdata[7:0]};
            o_rdata       = i_byte_sel ? {8'h00, i_rdata[15:8]} : {8'h00, i_rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller for the pipelined LC-3b.
// Cache handshake: a strobe (d_cache_read or d_cache_write) is raised with
// address/byte-enable/wdata registered alongside it; all of them hold steady
// until the cycle in which d_cache_resp=1, which completes that access.
// stall freezes upstream registers; it drops for exactly one DONE cycle so
// the finished instruction advances and is never re-issued.
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int WAIT_LIMIT = 255
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  lc3b_control_word ctrl,
    input  lc3b_word         addr,
    input  lc3b_word         wdata,
    input  logic             d_cache_resp,
    input  lc3b_word         d_cache_rdata,
    output logic             d_cache_read,
    output logic             d_cache_write,
    output lc3b_word         d_cache_address,
    output lc3b_word         d_cache_wdata,
    output logic [1:0]       d_cache_byte_enable,
    output lc3b_word         mem_rdata,
    output logic             stall,
    output logic             timeout,
    output mem_state_t       dbg_state
);

    localparam logic [7:0] LP_WAIT_LIMIT = 8'(WAIT_LIMIT);

    mem_state_t r_state;
    lc3b_opcode r_op;
    logic       r_is_write;
    logic       r_rd;
    logic       r_wr;
    lc3b_word   r_target;     // effective address, replaced by the fetched pointer for LDI/STI
    logic [1:0] r_be;
    lc3b_word   r_wdata_out;
    lc3b_word   r_rdata;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic       w_mem_op;
    logic       w_indirect;
    lc3b_opcode w_al_op;
    logic       w_al_sel;
    logic [1:0] w_al_be;
    lc3b_word   w_al_wdata;
    lc3b_word   w_al_rdata;

    assign w_mem_op   = valid & (ctrl.d_cache_read | ctrl.d_cache_write);
    assign w_indirect = is_indirect(ctrl.opcode);

    // Aligner sees live inputs in IDLE, the fetched pointer in IND, the latched target in ACC.
    always_comb begin
        w_al_op  = r_op;
        w_al_sel = r_target[0];
        case (r_state)
            IDLE:    begin
                w_al_op  = ctrl.opcode;
                w_al_sel = addr[0];
            end
            IND:     w_al_sel = d_cache_rdata[0];
            default: ;
        endcase
    end

    mem_byte_align u_align (
        .i_opcode      (w_al_op),
        .i_byte_sel    (w_al_sel),
        .i_wdata       (wdata),
        .i_rdata       (d_cache_rdata),
        .o_byte_enable (w_al_be),
        .o_wdata       (w_al_wdata),
        .o_rdata       (w_al_rdata)
    );

    // Stall is combinational in IDLE so the pipeline freezes on the first cycle of a memory op.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_mem_op;
            IND,
            ACC:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Access sequencing, operand capture, load-data capture and the wait/timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= op_br;
            r_is_write  <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_target    <= '0;
            r_be        <= 2'b00;
            r_wdata_out <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_op        <= ctrl.opcode;
                        r_is_write  <= ctrl.d_cache_write;
                        r_target    <= addr;
                        r_wdata_out <= w_al_wdata;
                        r_cnt       <= '0;
                        if (w_indirect) begin
                            r_state <= IND;
                            r_rd    <= 1'b1;
                            r_wr    <= 1'b0;
                            r_be    <= BE_WORD;
                        end else begin
                            r_state <= ACC;
                            r_rd    <= ~ctrl.d_cache_write;
                            r_wr    <= ctrl.d_cache_write;
                            r_be    <= w_al_be;
                        end
                    end
                end
                IND: begin
                    if (d_cache_resp) begin
                        r_target <= d_cache_rdata;
                        r_be     <= w_al_be;
                        r_rd     <= ~r_is_write;
                        r_wr     <= r_is_write;
                        r_cnt    <= '0;
                        r_state  <= ACC;
                    end
                end
                ACC: begin
                    if (d_cache_resp) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        if (!r_is_write) begin
                            r_rdata <= w_al_rdata;
                        end
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (((r_state == IND) || (r_state == ACC)) && !d_cache_resp) begin
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (r_cnt == LP_WAIT_LIMIT) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign d_cache_read        = r_rd;
    assign d_cache_write       = r_wr;
    assign d_cache_address     = {r_target[15:1], 1'b0};
    assign d_cache_byte_enable = r_be;
    assign d_cache_wdata       = r_wdata_out;
    assign mem_rdata           = r_rdata;
    assign timeout             = r_timeout;
    assign dbg_state           = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of transactions run through a small
// cache responder, with expected cache accesses queued per transaction,
// plus hand-written timeout, reset and idle-response sequences.
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    localparam int W = 35;  // {write, address, byte_enable, wdata}

    typedef struct {
        lc3b_opcode op;
        lc3b_word   addr;
        lc3b_word   wdata;
        lc3b_word   rdata1;
        lc3b_word   rdata2;
        int         delay;
        lc3b_word   exp_rdata;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             valid;
    lc3b_control_word ctrl;
    lc3b_word         addr;
    lc3b_word         wdata;
    logic             d_cache_resp;
    lc3b_word         d_cache_rdata;
    logic             d_cache_read;
    logic             d_cache_write;
    lc3b_word         d_cache_address;
    lc3b_word         d_cache_wdata;
    logic [1:0]       d_cache_byte_enable;
    lc3b_word         mem_rdata;
    logic             stall;
    logic             timeout;
    mem_state_t       dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;
    vec_t         tbl[11];

    mem_stage_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .valid               (valid),
        .ctrl                (ctrl),
        .addr                (addr),
        .wdata               (wdata),
        .d_cache_resp        (d_cache_resp),
        .d_cache_rdata       (d_cache_rdata),
        .d_cache_read        (d_cache_read),
        .d_cache_write       (d_cache_write),
        .d_cache_address     (d_cache_address),
        .d_cache_wdata       (d_cache_wdata),
        .d_cache_byte_enable (d_cache_byte_enable),
        .mem_rdata           (mem_rdata),
        .stall               (stall),
        .timeout             (timeout),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    function automatic bit op_is_write(input lc3b_opcode op);
        return (op == op_stb) || (op == op_str) || (op == op_sti);
    endfunction

    function automatic logic [W-1:0] mk_acc(input bit wr, input lc3b_word a,
                                             input logic [1:0] be, input lc3b_word wd);
        return {wr, a[15:1], 1'b0, be, (wr ? wd : 16'h0000)};
    endfunction

    // Expected cache accesses for one instruction, derived from its inputs.
    task automatic push_expected(input vec_t v);
        bit       wr;
        bit       byte_op;
        lc3b_word tgt;
        logic [1:0] be;
        lc3b_word wd;
        wr      = op_is_write(v.op);
        byte_op = (v.op == op_ldb) || (v.op == op_stb);
        tgt     = v.addr;
        if ((v.op == op_ldi) || (v.op == op_sti)) begin
            exp_q.push_back(mk_acc(1'b0, v.addr, 2'b11, 16'h0000));
            tgt = v.rdata1;
        end
        be = byte_op ? (tgt[0] ? 2'b10 : 2'b01) : 2'b11;
        wd = byte_op ? {v.wdata[7:0], v.wdata[7:0]} : v.wdata;
        exp_q.push_back(mk_acc(wr, tgt, be, wd));
    endtask

    // Drive one instruction, act as the cache, and check it through its DONE cycle.
    // Leaves the instruction on the inputs during DONE, as a real pipeline would.
    task automatic run_txn(input vec_t v, input int delay);
        int         stall_cnt;
        int         wt;
        int         acc;
        int         n_acc;
        bit         fin;
        logic [W-1:0] obs;
        logic [W-1:0] e;
        lc3b_word   prev_addr;
        logic [1:0] prev_be;
        @(posedge clk); #1;
        valid = 1'b1;
        ctrl  = '{opcode: v.op, d_cache_read: ~op_is_write(v.op), d_cache_write: op_is_write(v.op)};
        addr  = v.addr;
        wdata = v.wdata;
        d_cache_resp = 1'b0;
        push_expected(v);
        n_acc = ((v.op == op_ldi) || (v.op == op_sti)) ? 2 : 1;
        stall_cnt = 0;
        wt = 0;
        acc = 0;
        fin = 1'b0;
        prev_addr = '0;
        prev_be = '0;
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            if (stall) stall_cnt++;
            else fin = 1'b1;
            if (!fin && (d_cache_read || d_cache_write)) begin
                if (wt > 0) begin
                    check("addr_stable", 64'(d_cache_address), 64'(prev_addr));
                    check("be_stable", 64'(d_cache_byte_enable), 64'(prev_be));
                end
                prev_addr = d_cache_address;
                prev_be   = d_cache_byte_enable;
                if (wt == delay) begin
                    d_cache_resp  = 1'b1;
                    d_cache_rdata = (acc == 0) ? v.rdata1 : v.rdata2;
                    obs = {d_cache_write, d_cache_address, d_cache_byte_enable,
                           (d_cache_write ? d_cache_wdata : 16'h0000)};
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_access: got %h expected none", obs);
                    end else begin
                        e = exp_q.pop_front();
                        check("access", 64'(obs), 64'(e));
                    end
                    acc++;
                    wt = 0;
                end else begin
                    wt++;
                end
            end
            if (!fin) begin
                @(posedge clk); #1;
                d_cache_resp = 1'b0;
            end
        end
        check("reached_done", 64'(fin), 64'(1));
        check("done_state", 64'(dbg_state), 64'(DONE));
        check("done_strobes", 64'({d_cache_read, d_cache_write}), 64'(0));
        check("access_count", 64'(acc), 64'(n_acc));
        check("stall_cycles", 64'(stall_cnt), 64'(1 + n_acc * (delay + 1)));
        check("mem_rdata", 64'(mem_rdata), 64'(v.exp_rdata));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        valid = 1'b0;
        ctrl  = '{opcode: op_add, d_cache_read: 1'b0, d_cache_write: 1'b0};
        addr  = '0;
        wdata = '0;
        d_cache_resp  = 1'b0;
        d_cache_rdata = '0;

        tbl[0]  = '{op_ldr, 16'h1006, 16'h0000, 16'hBEEF, 16'h0000, 2, 16'hBEEF};
        tbl[1]  = '{op_stb, 16'h2001, 16'h00A5, 16'h0000, 16'h0000, 0, 16'hBEEF};
        tbl[2]  = '{op_ldb, 16'h2001, 16'h0000, 16'h7F12, 16'h0000, 1, 16'h007F};
        tbl[3]  = '{op_ldb, 16'h2000, 16'h0000, 16'h7F12, 16'h0000, 0, 16'h0012};
        tbl[4]  = '{op_ldi, 16'h3000, 16'h0000, 16'h4002, 16'h1234, 0, 16'h1234};
        tbl[5]  = '{op_sti, 16'h3000, 16'h5555, 16'h4002, 16'h0000, 1, 16'h1234};
        tbl[6]  = '{op_str, 16'h5003, 16'hCAFE, 16'h0000, 16'h0000, 0, 16'h1234};
        tbl[7]  = '{op_stb, 16'h2000, 16'h12C3, 16'h0000, 16'h0000, 2, 16'h1234};
        tbl[8]  = '{op_ldi, 16'h6000, 16'h0000, 16'h4003, 16'hA1B2, 1, 16'hA1B2};
        tbl[9]  = '{op_ldr, 16'h7FFF, 16'h0000, 16'h0F0F, 16'h0000, 0, 16'h0F0F};
        tbl[10] = '{op_ldb, 16'h8001, 16'h0000, 16'h80FF, 16'h0000, 3, 16'h0080};

        // Reset state
        @(posedge clk); #2;
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_strobes", 64'({d_cache_read, d_cache_write}), 64'(0));
        check("rst_mem_rdata", 64'(mem_rdata), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_address", 64'(d_cache_address), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Response while idle must be ignored
        d_cache_resp = 1'b1;
        d_cache_rdata = 16'hDEAD;
        @(posedge clk); #2;
        check("idle_resp_state", 64'(dbg_state), 64'(IDLE));
        check("idle_resp_strobes", 64'({d_cache_read, d_cache_write}), 64'(0));
        check("idle_resp_rdata", 64'(mem_rdata), 64'(0));
        d_cache_resp = 1'b0;

        // Table pass with fixed delays, then a pass with random delays, back to back
        for (int i = 0; i < 11; i++) run_txn(tbl[i], tbl[i].delay);
        for (int i = 0; i < 11; i++) run_txn(tbl[i], int'($urandom_range(0, 3)));
        @(posedge clk); #1;
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("idle_after_strobes", 64'({d_cache_read, d_cache_write}), 64'(0));
        end
        check("no_timeout_yet", 64'(timeout), 64'(0));

        // Timeout: no response for 10 ACC cycles, then a late response
        @(posedge clk); #1;
        valid = 1'b1;
        ctrl  = '{opcode: op_ldr, d_cache_read: 1'b1, d_cache_write: 1'b0};
        addr  = 16'h0100;
        #1;
        check("to_stall_idle", 64'(stall), 64'(1));
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #2;
            if (c == 4) check("to_not_yet", 64'(timeout), 64'(0));
            if (c >= 6) check("to_set", 64'(timeout), 64'(1));
            check("to_read_held", 64'(d_cache_read), 64'(1));
            check("to_stall_held", 64'(stall), 64'(1));
        end
        d_cache_resp  = 1'b1;
        d_cache_rdata = 16'h5A5A;
        @(posedge clk); #1;
        d_cache_resp = 1'b0;
        #1;
        check("late_done", 64'(dbg_state), 64'(DONE));
        check("late_rdata", 64'(mem_rdata), 64'(16'h5A5A));
        check("late_stall", 64'(stall), 64'(0));
        valid = 1'b0;
        @(posedge clk); #2;
        check("to_sticky", 64'(timeout), 64'(1));
        check("to_idle", 64'(dbg_state), 64'(IDLE));

        // Reset in the middle of an ACC wait
        @(posedge clk); #1;
        valid = 1'b1;
        ctrl  = '{opcode: op_ldr, d_cache_read: 1'b1, d_cache_write: 1'b0};
        addr  = 16'h0200;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("mid_acc_read", 64'(d_cache_read), 64'(1));
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check("mid_rst_strobes", 64'({d_cache_read, d_cache_write}), 64'(0));
        check("mid_rst_stall", 64'(stall), 64'(0));
        check("mid_rst_timeout", 64'(timeout), 64'(0));
        check("mid_rst_rdata", 64'(mem_rdata), 64'(0));
        reset = 1'b0;

        // Normal operation resumes after the abandoned access
        run_txn(tbl[3], 1);
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
